dbus_sram_responder: RTL and testbench
======================================

# dbus_sram_responder

Data-bus responder that serves `dbus_req_t` requests from the memory stage and answers with `dbus_resp_t`. It holds a word-organised SRAM, applies byte-strobed writes, and returns full 64-bit words after a configurable latency. The memory stage performs byte-lane shifting and sign extension itself. The block sits on the far side of the data-bus interface and serves as the data memory for simulation and for the on-chip scratchpad.

## Interface
Parameters:
- `DEPTH_WORDS`, default 4096: number of 64-bit words; must be a power of two.
- `BASE_ADDR`, default 64'h8000_0000: byte address of word 0; must be 8-byte aligned.
- `LATENCY`, default 2: cycles from acceptance to response; must be ≥1.

Ports:
- `clk`  in  1: clock. One clock; every state element is on its rising edge.
- `reset`  in  1: reset. Synchronous and active-high.
- `dreq`  in  `dbus_req_t`: request fields `valid`, `addr`[63:0], `size` (`msize_t`), `strobe`[7:0], `data`[63:0].
- `dresp`  out  `dbus_resp_t`: response fields `addr_ok`, `data_ok`, `data`[63:0].

## Operation
- State machine with three states: IDLE, WAIT, RESP.
- IDLE:
  - If `dreq.valid`=1, capture `addr`, `strobe` and `data` into a request register.
  - Write flag = (`strobe` != 0). A read is any request with `strobe` = 0.
  - Load the countdown with LATENCY-1.
  - Go to RESP if the count is 0; otherwise go to WAIT.
- WAIT: decrement the count each cycle; go to RESP when it reaches 0.
- RESP: hold for exactly one cycle, then return to IDLE.
  - Drive `addr_ok`=1 and `data_ok`=1.
  - `dresp.data` = the stored word at the captured index, read before any write in this cycle.
  - On a write, update byte i of the word (bits 8i+7:8i) with captured `data` byte i for each set `strobe[i]`. All other bytes are unchanged.
- Index and range:
  - Index = (captured `addr` − BASE_ADDR)[63:3].
  - Out of range when `addr` < BASE_ADDR or index ≥ DEPTH_WORDS.
  - Out-of-range reads return 0. Out-of-range writes are dropped. The handshake completes normally in both cases.
- `addr[2:0]` and `size` do not affect word selection. `size` is accepted and ignored; only `strobe` selects bytes.
- `dreq` changes while the block is in WAIT or RESP are ignored, because the request was captured at acceptance.
- SRAM contents are not cleared by reset.

## Timing
- Reset values: `addr_ok`=0, `data_ok`=0, `data`=64'h0. State = IDLE, count = 0.
- Outside RESP, `addr_ok`, `data_ok` and `data` are all 0.
- Latency:
  - Request accepted in cycle k (IDLE with `valid`=1 at the rising edge ending cycle k).
  - Response is visible in cycle k+LATENCY.
  - LATENCY=1 gives the response in the cycle after acceptance.
- One outstanding request at a time. The earliest next acceptance is the IDLE cycle after RESP. Throughput is one request per LATENCY+1 cycles.
- The requester keeps `valid` high until it sees `data_ok`. In the cycle after `data_ok` it either deasserts `valid` or presents the next request. A `valid` still high in that cycle is treated as a new request.
- Reset asserted in WAIT or RESP:
  - The in-flight request is discarded and no write is performed.
  - Outputs go to their reset values in the following cycle.
- A write and a following read to the same word: the read returns the written data, because the write commits in RESP and the read accepts at the earliest in the next cycle.

## Configuration
- Macro `DBUS_SRAM_RAND_LATENCY_EN`.
  - Defined:
    - An 8-bit Fibonacci LFSR (taps 8,6,5,4) reset to 8'hA5 advances every cycle.
    - At acceptance, the countdown loads LATENCY-1 + `lfsr[1:0]`, giving a response latency of LATENCY to LATENCY+3 cycles.
    - This stresses requester stall logic.
  - Not defined: the LFSR is absent and latency is exactly LATENCY.

## Test plan
- **Reset values:** hold `reset` 3 cycles with `dreq.valid`=1 → `addr_ok`/`data_ok`/`data` = 0 throughout, and no acceptance.
- **Full store then load, LATENCY=2:**
  - Write `addr`=0x8000_0010, `strobe`=8'hFF, `data`=64'h1122_3344_5566_7788 → `data_ok` one cycle, 2 cycles after acceptance.
  - Then read the same address → `data`=64'h1122_3344_5566_7788.
- **Partial store (`sb`):**
  - Write `addr`=0x8000_0013, `strobe`=8'h08, `data`=64'hAB00_0000 over word 0x0 → read of 0x8000_0010 returns 64'h0000_0000_AB00_0000.
  - Read of 0x8000_0014 (same word) returns the same value.
- **Out of range:**
  - Write to 0x7FFF_FFF8 → `data_ok` asserted and no SRAM change.
  - Read of BASE+8·DEPTH_WORDS → `data`=0.
- **Reset mid-op:** write 64'hFFFF to 0x8000_0020, assert `reset` in the WAIT cycle → a later read of 0x8000_0020 returns its prior value (0 if previously written to 0).
- **Back-to-back and random latency:**
  - Without the macro: 3 consecutive reads with `valid` held high → `data_ok` in cycles 2, 5 and 8 after the first acceptance.
  - With `DBUS_SRAM_RAND_LATENCY_EN`: every latency falls in [2,5], and all data matches the reference model.

Source files
------------

// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: word-organised memory with byte-strobed writes and fixed latency.
// Optional macro DBUS_SRAM_RAND_LATENCY_EN adds 0..3 extra LFSR-driven cycles of latency.
package dbus_pkg;
  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt_s, cnt_load_s;
  logic               accept_s;
  logic [63:0]        offset_s;
  logic [IDX_W-1:0]   idx_s, idx_r, rd_idx_s;
  logic               in_range_s, in_range_r, rd_ok_s;
  logic               is_write_r;
  logic [7:0]         strobe_r;
  logic [63:0]        wdata_r;
  logic [63:0]        mem [DEPTH_WORDS];
  dbus_resp_t         resp_r;
  logic               unused_bits_s;

  assign offset_s      = dreq.addr - BASE_ADDR;
  assign idx_s         = offset_s[IDX_W+2:3];
  assign in_range_s    = (dreq.addr >= BASE_ADDR) && (offset_s[63:IDX_W+3] == '0);
  assign unused_bits_s = ^{dreq.size, offset_s[2:0]};

`ifdef DBUS_SRAM_RAND_LATENCY_EN
  logic [7:0] lfsr_r;

  // Fibonacci LFSR, taps 8,6,5,4, free-running
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_r <= 8'hA5;
    end else begin
      lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
    end
  end

  assign cnt_load_s = CNT_W'(LATENCY - 1) + CNT_W'(lfsr_r[1:0]);
`else
  assign cnt_load_s = CNT_W'(LATENCY - 1);
`endif

  // State and countdown registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic and countdown
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (dreq.valid) begin
          accept_s  = 1'b1;
          cnt_nxt_s = cnt_load_s;
          if (cnt_load_s == {CNT_W{1'b0}}) begin
            state_nxt_s = RESP;
          end else begin
            state_nxt_s = WAIT;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        cnt_nxt_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // With a zero countdown the response is loaded on the accept edge, before the capture lands
  always_comb begin
    rd_idx_s = idx_r;
    rd_ok_s  = in_range_r;
    if (accept_s) begin
      rd_idx_s = idx_s;
      rd_ok_s  = in_range_s;
    end else begin
      rd_idx_s = idx_r;
      rd_ok_s  = in_range_r;
    end
  end

  // Request capture at acceptance
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r      <= {IDX_W{1'b0}};
      in_range_r <= 1'b0;
      is_write_r <= 1'b0;
      strobe_r   <= 8'h00;
      wdata_r    <= 64'h0;
    end else if (accept_s) begin
      idx_r      <= idx_s;
      in_range_r <= in_range_s;
      is_write_r <= (dreq.strobe != 8'h00);
      strobe_r   <= dreq.strobe;
      wdata_r    <= dreq.data;
    end
  end

  // Registered response, loaded on the edge entering RESP (read-before-write)
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_r <= '0;
    end else if (state_nxt_s == RESP) begin
      resp_r.addr_ok <= 1'b1;
      resp_r.data_ok <= 1'b1;
      resp_r.data    <= rd_ok_s ? mem[rd_idx_s] : 64'h0;
    end else begin
      resp_r <= '0;
    end
  end

  // Byte-strobed write commits at the end of RESP; memory itself is never cleared
  always_ff @(posedge clk) begin
    if (!reset && (state_r == RESP) && is_write_r && in_range_r) begin
      for (int i = 0; i < 8; i++) begin
        if (strobe_r[i]) begin
          mem[idx_r][8*i +: 8] <= wdata_r[8*i +: 8];
        end
      end
    end
  end

  assign dresp = resp_r;

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed self-checking bench for dbus_sram_responder (LATENCY=2, DEPTH_WORDS=4096).
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  dbus_sram_responder #(
    .DEPTH_WORDS(4096),
    .BASE_ADDR  (64'h8000_0000),
    .LATENCY    (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .dreq (dreq),
    .dresp(dresp)
  );

  // Issue one request from an IDLE cycle; return data, latency and whether outputs cleared afterwards.
  task automatic do_req(input logic [63:0] a, input logic [7:0] s, input logic [63:0] d,
                        output logic [63:0] rdata, output int lat, output logic tail_ok);
    dreq.valid  = 1'b1;
    dreq.addr   = a;
    dreq.size   = MSIZE8;
    dreq.strobe = s;
    dreq.data   = d;
    lat   = -1;
    rdata = 64'h0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (dresp.data_ok === 1'b1) begin
        lat   = n;
        rdata = dresp.data;
        break;
      end
    end
    dreq.valid = 1'b0;
    @(posedge clk); #1;
    tail_ok = (dresp === '0);
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0010;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hDEAD_BEEF;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (dresp !== '0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got %h want 0", i, dresp);
      end
      @(posedge clk); #1;
    end
    reset      = 1'b0;
    dreq.valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (dresp !== '0) begin
        bad++;
        $display("FAIL reset_no_accept[%0d]: got %h want 0", i, dresp);
      end
    end
  endtask

  task automatic test_full_store_load();
    logic [63:0] rd;
    int          lat;
    logic        tail;
    do_req(64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, rd, lat, tail);
    total++;
`ifdef DBUS_SRAM_RAND_LATENCY_EN
    if (lat < 2 || lat > 5) begin
`else
    if (lat != 2) begin
`endif
      bad++;
      $display("FAIL full_wr_latency: got %0d want 2", lat);
    end
    total++;
    if (!tail) begin
      bad++;
      $display("FAIL full_wr_one_cycle: got %h want 0", dresp);
    end
    do_req(64'h8000_0010, 8'h00, 64'h0, rd, lat, tail);
    total++;
    if (rd !== 64'h1122_3344_5566_7788) begin
      bad++;
      $display("FAIL full_rd_data: got %h want %h", rd, 64'h1122_3344_5566_7788);
    end
    total++;
`ifdef DBUS_SRAM_RAND_LATENCY_EN
    if (lat < 2 || lat > 5) begin
`else
    if (lat != 2) begin
`endif
      bad++;
      $display("FAIL full_rd_latency: got %0d want 2", lat);
    end
  endtask

  task automatic test_partial_store();
    logic [63:0] rd;
    int          lat;
    logic        tail;
    do_req(64'h8000_0010, 8'hFF, 64'h0, rd, lat, tail);
    do_req(64'h8000_0013, 8'h08, 64'hAB00_0000, rd, lat, tail);
    do_req(64'h8000_0010, 8'h00, 64'h0, rd, lat, tail);
    total++;
    if (rd !== 64'h0000_0000_AB00_0000) begin
      bad++;
      $display("FAIL sb_rd_10: got %h want %h", rd, 64'h0000_0000_AB00_0000);
    end
    do_req(64'h8000_0014, 8'h00, 64'h0, rd, lat, tail);
    total++;
    if (rd !== 64'h0000_0000_AB00_0000) begin
      bad++;
      $display("FAIL sb_rd_14: got %h want %h", rd, 64'h0000_0000_AB00_0000);
    end
    do_req(64'h8000_0018, 8'hFF, 64'h0, rd, lat, tail);
    do_req(64'h8000_0018, 8'h81, 64'hFFEE_DDCC_BBAA_9988, rd, lat, tail);
    do_req(64'h8000_001C, 8'h00, 64'h0, rd, lat, tail);
    total++;
    if (rd !== 64'hFF00_0000_0000_0088) begin
      bad++;
      $display("FAIL strobe_81: got %h want %h", rd, 64'hFF00_0000_0000_0088);
    end
  endtask

  task automatic test_out_of_range();
    logic [63:0] rd;
    int          lat;
    logic        tail;
    // The last word and word 0 are the alias targets if the range check is missing.
    do_req(64'h8000_7FF8, 8'hFF, 64'h5A5A_0000_1234_5678, rd, lat, tail);
    do_req(64'h8000_0000, 8'hFF, 64'h0123_4567_89AB_CDEF, rd, lat, tail);
    do_req(64'h7FFF_FFF8, 8'hFF, 64'hDEAD_DEAD_DEAD_DEAD, rd, lat, tail);
    total++;
    if (lat < 0) begin
      bad++;
      $display("FAIL oor_wr_handshake: got no data_ok want data_ok");
    end
    total++;
    if (rd !== 64'h0) begin
      bad++;
      $display("FAIL oor_wr_data: got %h want 0", rd);
    end
    do_req(64'h8000_7FF8, 8'h00, 64'h0, rd, lat, tail);
    total++;
    if (rd !== 64'h5A5A_0000_1234_5678) begin
      bad++;
      $display("FAIL oor_wr_dropped: got %h want %h", rd, 64'h5A5A_0000_1234_5678);
    end
    do_req(64'h8000_8000, 8'h00, 64'h0, rd, lat, tail);
    total++;
    if (rd !== 64'h0 || lat < 0) begin
      bad++;
      $display("FAIL oor_rd: got %h lat %0d want 0", rd, lat);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] rd;
    int          lat;
    logic        tail;
    do_req(64'h8000_0020, 8'hFF, 64'h0, rd, lat, tail);
    do_req(64'h8000_0028, 8'hFF, 64'h0, rd, lat, tail);
    // reset asserted in the WAIT cycle
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0020;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hFFFF;
    @(posedge clk); #1;
    total++;
    if (dresp !== '0) begin
      bad++;
      $display("FAIL wait_outputs: got %h want 0", dresp);
    end
    reset      = 1'b1;
    dreq.valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      total++;
      if (dresp !== '0) begin
        bad++;
        $display("FAIL wait_reset_quiet[%0d]: got %h want 0", i, dresp);
      end
    end
    do_req(64'h8000_0020, 8'h00, 64'h0, rd, lat, tail);
    total++;
    if (rd !== 64'h0) begin
      bad++;
      $display("FAIL wait_reset_no_write: got %h want 0", rd);
    end
    // reset asserted in the RESP cycle
    dreq.valid  = 1'b1;
    dreq.addr   = 64'h8000_0028;
    dreq.strobe = 8'hFF;
    dreq.data   = 64'hFFFF;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (dresp.data_ok === 1'b1) begin
        lat = n;
        break;
      end
    end
    total++;
    if (lat < 0) begin
      bad++;
      $display("FAIL resp_reached: got no data_ok want data_ok");
    end
    reset      = 1'b1;
    dreq.valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (dresp !== '0) begin
      bad++;
      $display("FAIL resp_reset_outputs: got %h want 0", dresp);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    do_req(64'h8000_0028, 8'h00, 64'h0, rd, lat, tail);
    total++;
    if (rd !== 64'h0) begin
      bad++;
      $display("FAIL resp_reset_no_write: got %h want 0", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs [3];
    logic [63:0] exp   [3];
    int          want  [3];
    int          idx;
    addrs[0] = 64'h8000_0010; exp[0] = 64'h0000_0000_AB00_0000; want[0] = 2;
    addrs[1] = 64'h8000_0018; exp[1] = 64'hFF00_0000_0000_0088; want[1] = 5;
    addrs[2] = 64'h8000_0000; exp[2] = 64'h0123_4567_89AB_CDEF; want[2] = 8;
    idx = 0;
    dreq.valid  = 1'b1;
    dreq.addr   = addrs[0];
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    for (int c = 1; c <= 24; c++) begin
      @(posedge clk); #1;
      if (dresp.data_ok === 1'b1) begin
        if (idx < 3) begin
`ifndef DBUS_SRAM_RAND_LATENCY_EN
          total++;
          if (c != want[idx]) begin
            bad++;
            $display("FAIL b2b_cycle[%0d]: got %0d want %0d", idx, c, want[idx]);
          end
`endif
          total++;
          if (dresp.data !== exp[idx]) begin
            bad++;
            $display("FAIL b2b_data[%0d]: got %h want %h", idx, dresp.data, exp[idx]);
          end
        end
        idx++;
        if (idx < 3) begin
          dreq.addr = addrs[idx];
        end else begin
          dreq.valid = 1'b0;
        end
      end
    end
    total++;
    if (idx != 3) begin
      bad++;
      $display("FAIL b2b_count: got %0d want 3", idx);
    end
  endtask

  initial begin
    reset = 1'b1;
    dreq  = '0;
    test_reset();
    test_full_store_load();
    test_partial_store();
    test_out_of_range();
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
